// File: rtl/window_gen_3x3.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 shift window, taps registered one cycle after the accepting beat.
// No backpressure. Define WINDOW_STRIDE2_EN to emit only windows whose bottom-right pixel sits on even row and column.
module window_gen_3x3 #(
   parameter int DATA_WIDTH = 32,
   parameter int IMG_WIDTH  = 28,
   parameter int IMG_HEIGHT = 28
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  valid_in,
   output logic [DATA_WIDTH-1:0] data_out0,
   output logic [DATA_WIDTH-1:0] data_out1,
   output logic [DATA_WIDTH-1:0] data_out2,
   output logic [DATA_WIDTH-1:0] data_out3,
   output logic [DATA_WIDTH-1:0] data_out4,
   output logic [DATA_WIDTH-1:0] data_out5,
   output logic [DATA_WIDTH-1:0] data_out6,
   output logic [DATA_WIDTH-1:0] data_out7,
   output logic [DATA_WIDTH-1:0] data_out8,
   output logic                  valid_out,
   output logic                  frame_done
);
   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

   logic [CW-1:0]         col_q, col_d;
   logic [RW-1:0]         row_q, row_d;
   logic [DATA_WIDTH-1:0] lb1_q [IMG_WIDTH];
   logic [DATA_WIDTH-1:0] lb2_q [IMG_WIDTH];
   logic [DATA_WIDTH-1:0] win_q [9];
   logic [DATA_WIDTH-1:0] win_d [9];
   logic [DATA_WIDTH-1:0] out_q [9];
   logic                  valid_q;
   logic                  frame_done_q;
   logic                  emit;
   logic                  last_pix;

   always_comb begin
      col_d    = col_q;
      row_d    = row_q;
      last_pix = (col_q == COL_LAST) && (row_q == ROW_LAST);
      if (col_q == COL_LAST) begin
         col_d = '0;
         row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
         col_d = col_q + CW'(1);
      end

      // Shift left one column; the new right column is {row-2, row-1, incoming}.
      for (int r = 0; r < 3; r++) begin
         win_d[3*r]     = win_q[3*r+1];
         win_d[3*r + 1] = win_q[3*r+2];
      end
      win_d[2] = lb2_q[col_q];
      win_d[5] = lb1_q[col_q];
      win_d[8] = data_in;

`ifdef WINDOW_STRIDE2_EN
      emit = (row_q >= RW'(2)) && (col_q >= CW'(2)) && !row_q[0] && !col_q[0];
`else
      emit = (row_q >= RW'(2)) && (col_q >= CW'(2));
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_q        <= '0;
         row_q        <= '0;
         valid_q      <= 1'b0;
         frame_done_q <= 1'b0;
         for (int i = 0; i < 9; i++) begin
            win_q[i] <= '0;
            out_q[i] <= '0;
         end
      end else begin
         valid_q      <= 1'b0;
         frame_done_q <= 1'b0;
         if (valid_in) begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_q        <= win_d;
            valid_q      <= emit;
            frame_done_q <= last_pix;
            if (emit) begin
               out_q <= win_d;
            end
         end
      end
   end

   // Line buffers are deliberately left unreset; the emit gating never exposes stale entries.
   always_ff @(posedge clk) begin
      if (valid_in) begin
         lb2_q[col_q] <= lb1_q[col_q];
         lb1_q[col_q] <= data_in;
      end
   end

   assign data_out0  = out_q[0];
   assign data_out1  = out_q[1];
   assign data_out2  = out_q[2];
   assign data_out3  = out_q[3];
   assign data_out4  = out_q[4];
   assign data_out5  = out_q[5];
   assign data_out6  = out_q[6];
   assign data_out7  = out_q[7];
   assign data_out8  = out_q[8];
   assign valid_out  = valid_q;
   assign frame_done = frame_done_q;
endmodule

// File: tb/tb_window_gen_3x3.sv
// Bench for window_gen_3x3 on a 5x5 image: a frame-array reference model predicts every cycle's outputs.
module tb_window_gen_3x3;
   localparam int W  = 5;
   localparam int H  = 5;
   localparam int DW = 32;
`ifdef WINDOW_STRIDE2_EN
   localparam int WPF = ((H-3)/2 + 1) * ((W-3)/2 + 1);
`else
   localparam int WPF = (H-2) * (W-2);
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          valid_in = 1'b0;
   logic [DW-1:0] data_in = '0;
   logic [DW-1:0] dout [9];
   logic          valid_out;
   logic          frame_done;

   int checks = 0;
   int errors = 0;
   int strobes;
   int fdones;

   logic [DW-1:0] img [H][W];
   logic [DW-1:0] exp_out [9];
   logic          exp_vld;
   logic          exp_fd;
   int            m_row;
   int            m_col;

   always #5 clk = ~clk;

   window_gen_3x3 #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
      .data_out0(dout[0]), .data_out1(dout[1]), .data_out2(dout[2]),
      .data_out3(dout[3]), .data_out4(dout[4]), .data_out5(dout[5]),
      .data_out6(dout[6]), .data_out7(dout[7]), .data_out8(dout[8]),
      .valid_out(valid_out), .frame_done(frame_done)
   );

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      m_row   = 0;
      m_col   = 0;
      exp_vld = 1'b0;
      exp_fd  = 1'b0;
      for (int i = 0; i < 9; i++) exp_out[i] = '0;
   endtask

   function automatic logic window_due(input int r, input int c);
`ifdef WINDOW_STRIDE2_EN
      return (r >= 2) && (c >= 2) && (r % 2 == 0) && (c % 2 == 0);
`else
      return (r >= 2) && (c >= 2);
`endif
   endfunction

   // Called at a falling edge: drive one cycle, predict, then check at the next falling edge.
   task automatic step(input logic v, input logic [DW-1:0] d);
      valid_in = v;
      data_in  = d;
      exp_vld  = 1'b0;
      exp_fd   = 1'b0;
      if (v) begin
         img[m_row][m_col] = d;
         exp_fd = (m_row == H-1) && (m_col == W-1);
         if (window_due(m_row, m_col)) begin
            exp_vld = 1'b1;
            for (int i = 0; i < 9; i++) exp_out[i] = img[m_row-2+i/3][m_col-2+i%3];
         end
         if (m_col == W-1) begin
            m_col = 0;
            m_row = (m_row == H-1) ? 0 : m_row + 1;
         end else begin
            m_col = m_col + 1;
         end
      end
      @(posedge clk);
      @(negedge clk);
      chk("valid_out", {31'b0, valid_out}, {31'b0, exp_vld});
      chk("frame_done", {31'b0, frame_done}, {31'b0, exp_fd});
      for (int i = 0; i < 9; i++) chk($sformatf("tap%0d", i), dout[i], exp_out[i]);
      if (valid_out === 1'b1) strobes++;
      if (frame_done === 1'b1) fdones++;
   endtask

   initial begin
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_valid_out", {31'b0, valid_out}, 32'd0);
      chk("rst_frame_done", {31'b0, frame_done}, 32'd0);
      for (int i = 0; i < 9; i++) chk($sformatf("rst_tap%0d", i), dout[i], 32'd0);
      rst = 1'b1;
      for (int k = 0; k < 20; k++) step(1'b0, $urandom);

      // Single frame, sequential pixels
      strobes = 0; fdones = 0;
      for (int p = 0; p < W*H; p++) step(1'b1, p);
      chk("frame1_strobes", strobes, WPF);
      chk("frame1_done", fdones, 1);

      // Random pixels with random idle gaps
      strobes = 0; fdones = 0;
      for (int p = 0; p < W*H; p++) begin
         step(1'b1, $urandom);
         if (p < W*H-1) begin
            int gap = $urandom_range(1, 4);
            for (int g = 0; g < gap; g++) step(1'b0, $urandom);
         end
      end
      chk("gapped_strobes", strobes, WPF);
      chk("gapped_done", fdones, 1);

      // Two frames back-to-back
      strobes = 0; fdones = 0;
      for (int p = 0; p < 2*W*H; p++) step(1'b1, p);
      chk("b2b_strobes", strobes, 2*WPF);
      chk("b2b_done", fdones, 2);

      // Reset asserted mid-frame after pixel 13
      for (int p = 0; p < 14; p++) step(1'b1, p);
      valid_in = 1'b0;
      rst = 1'b0;
      #1;
      chk("midrst_valid_out", {31'b0, valid_out}, 32'd0);
      chk("midrst_frame_done", {31'b0, frame_done}, 32'd0);
      for (int i = 0; i < 9; i++) chk($sformatf("midrst_tap%0d", i), dout[i], 32'd0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      strobes = 0; fdones = 0;
      for (int p = 0; p < W*H; p++) step(1'b1, p);
      chk("restart_strobes", strobes, WPF);
      chk("restart_done", fdones, 1);
      for (int k = 0; k < 4; k++) step(1'b0, $urandom);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
